// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Drives the select lines of an 8:1 mux through all eight channels on each
//   start request. For every channel it waits SETTLE cycles and then samples
//   the mux output. The eight samples form one parallel word.
//
// Parameters:
//   SETTLE   wait cycles between a select change and its sample (1..15)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   start     in   scan request, only honoured while idle
//   mux_in    in   mux output o1
//   s1,s2,s3  out  mux selects, {s1,s2,s3} = current channel index
//   data_out  out  last completed scan, bit k = channel a(k+1)
//   busy      out  high while a scan is in progress
//   done      out  one-cycle pulse when data_out updates
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_in,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state, state_n;
  logic [2:0] ch, ch_n;
  logic [3:0] cnt, cnt_n;
  // Channel 7 never needs storage: it goes straight into data_out.
  logic [6:0] cap, cap_n;
  logic [7:0] data_n;
  logic       busy_n;
  logic       done_n;

  always_comb begin
    state_n = state;
    ch_n    = ch;
    cnt_n   = cnt;
    cap_n   = cap;
    data_n  = data_out;
    busy_n  = busy;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = WAIT;
          ch_n    = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end
      end

      WAIT: begin
        cnt_n = cnt + 4'd1;
        if (cnt == CNT_LAST) begin
          state_n = SAMPLE;
        end
      end

      SAMPLE: begin
        if (ch != 3'd7) begin
          for (int unsigned i = 0; i < 7; i++) begin
            if (ch == 3'(i)) begin
              cap_n[i] = mux_in;
            end
          end
          ch_n    = ch + 3'd1;
          cnt_n   = '0;
          state_n = WAIT;
        end else begin
          data_n  = {mux_in, cap};
          done_n  = 1'b1;
          busy_n  = 1'b0;
          ch_n    = '0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ch       <= '0;
      cnt      <= '0;
      cap      <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      ch       <= ch_n;
      cnt      <= cnt_n;
      cap      <= cap_n;
      data_out <= data_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Selects come straight from the channel register so the mux sees no glitches.
  assign {s1, s2, s3} = ch;

endmodule
